keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Autonomous scan controller for the 20-key LCDS keypad matrix (hex 0-F, RUN, MEM, HALT, INIT).
- Drives the 5 column strobes one at a time and samples the 4 row returns.
- Debounces whole-matrix snapshots and queues press events (optionally releases) as 5-bit key codes in a small FIFO with a valid/ready interface.
- Sits between the physical matrix and the front-panel logic that consumes key events, replacing CPU-timed column strobing.

Parameters:
- SETTLE_CYCLES, 16: clocks a column is driven before rows are sampled; legal range 1-255.
- DEBOUNCE_SCANS, 3: number of consecutive identical full-matrix snapshots needed to accept a new state; legal range 1-15.
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2-16.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- scan_en  in  1  high: scanning runs; low: scanning stops at the next column boundary.
- col  out  5  one-hot column strobe, active high; 0 when idle.
- row  in  4  row returns, active high, already synchronised to clk.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head entry when evt_valid && evt_ready.
- evt_key  out  5  key code of the head entry, 0-19.
- evt_release  out  1  head entry is a release; constant 0 without the optional feature.
- keys  out  20  current debounced key state, bit n = key code n.
- overflow  out  1  sticky; set when an event is dropped; cleared by reset only.

Behaviour:
- Reset (async assert, sync release): state IDLE; col=0; keys=0; FIFO empty; evt_valid=0; evt_key=0; evt_release=0; overflow=0; snapshots and counters cleared.
- Key code map:
  - col[4]: row[3:0] -> codes 3..0.
  - col[3]: row[3:0] -> codes 7..4.
  - col[2]: row[3:0] -> codes 11..8.
  - col[1]: row[3:0] -> codes 15..12.
  - col[0]: row[1] -> code 16 (RUN), row[2] -> code 17 (MEM).
  - col[0]: row[0] -> code 18 (HALT), row[3] -> code 19 (INIT).
- FSM states: IDLE, DRIVE, SAMPLE, COMPARE, EMIT.
  - IDLE: col=0. Go to DRIVE with column index 4 when scan_en=1.
  - DRIVE: col = one-hot(index); wait counter runs SETTLE_CYCLES clocks, then go to SAMPLE.
  - SAMPLE: one clock; row is captured into the raw snapshot bits for that column; col stays asserted.
    - Index > 0: decrement index and go to DRIVE.
    - Index = 0: go to COMPARE.
    - scan_en=0 here: go to IDLE and discard the partial snapshot.
  - COMPARE: one clock.
    - Raw snapshot equals previous raw snapshot: stable counter saturating-increments. Otherwise stable counter resets to 1.
    - Stable counter >= DEBOUNCE_SCANS and raw != keys: pending mask = raw XOR keys; keys <= raw; go to EMIT.
    - Otherwise: go to DRIVE with index 4, or to IDLE if scan_en=0.
  - EMIT: one event per clock, lowest set pending bit first. Press: pending bit and new key=1. Release: new key=0.
    - Release events are cleared from pending without a push when the feature is off.
    - Pending empty: go to DRIVE (or IDLE).
- Full scan period = 5*(SETTLE_CYCLES+1)+1 clocks, plus EMIT cycles.
- FIFO:
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push while full with no pop: event dropped, overflow set, EMIT still advances. The scan never stalls on the consumer.
  - Pop while empty: ignored.
  - evt_key/evt_release show the head entry combinationally from registered storage. They hold their value while evt_valid=0.
- keys updates only in COMPARE and may change while events are still queued.
- Reset asserted mid-scan or mid-EMIT: all state, pending events and FIFO contents are discarded immediately.

Optional Feature:
- Macro: KEYPAD_SCAN_RELEASE_EN.
- Defined: release transitions are queued with evt_release=1, in the same lowest-first order, interleaved with presses.
- Undefined: only presses are queued, evt_release is tied to 0, and release transitions only update keys.

Test Plan:
- Reset, then scan_en=1, no keys held -> col sequence 10000, 01000, 00100, 00010, 00001, each driven 17 clocks with defaults; evt_valid stays 0; keys=0.
- Hold key 5 (row[1] high only while col[3]=1) for 4 full scans, evt_ready=1 -> exactly one event, key=5, release=0; keys=20'h00020 after the 3rd identical snapshot.
- Hold keys 2 and 17 together, evt_ready=0 -> FIFO holds key 2 then key 17, evt_valid=1; raise evt_ready -> pops in that order, then evt_valid=0.
- Toggle key 9 every scan (bounce) for 10 scans, then hold it -> no event during the bounce; a single key=9 event after 3 stable scans.
- With evt_ready=0, press 6 distinct keys -> first 4 queued; overflow=1 after the 5th event; keys shows all 6 set.
- Feature defined: press then release key 18 -> events (18,0) then (18,1); feature undefined -> only (18,0). Also assert reset_n low mid-DRIVE -> col=0 and evt_valid=0 asynchronously.

Source files
------------

// File: rtl/keypad_scan.sv
// ============================================================================
//  Module      : keypad_scan
//  Description : Autonomous 5x4 keypad matrix scanner with whole-matrix
//                debounce and a valid/ready key-event FIFO.
//                Optional macro KEYPAD_SCAN_RELEASE_EN also queues releases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scan_en,
    output logic [4:0]  col,
    input  logic [3:0]  row,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [4:0]  evt_key,
    output logic        evt_release,
    output logic [19:0] keys,
    output logic        overflow
);

    localparam int             c_PW         = $clog2(FIFO_DEPTH);
    localparam logic [c_PW:0]  c_DEPTH      = FIFO_DEPTH[c_PW:0];
    localparam logic [7:0]     c_SETTLE_END = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]     c_DEB        = 4'(DEBOUNCE_SCANS);
`ifdef KEYPAD_SCAN_RELEASE_EN
    localparam int             c_EW         = 6;
`else
    localparam int             c_EW         = 5;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_SAMPLE  = 3'd2,
        S_COMPARE = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    state_t        r_state;
    logic [2:0]    r_idx;
    logic [7:0]    r_cnt;
    logic [4:0]    r_col;
    logic [19:0]   r_raw;
    logic [19:0]   r_prev;
    logic [3:0]    r_stable;
    logic [19:0]   r_keys;
    logic [19:0]   r_pend;
    logic          r_ovf;

    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_EW-1:0] r_last;
    logic [c_PW-1:0] r_wr;
    logic [c_PW-1:0] r_rd;
    logic [c_PW:0]   r_count;

    logic [3:0]      w_stable_next;
    logic [4:0]      w_bit;
    logic            w_is_rel;
    logic            w_emit;
    logic            w_push;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_full;
    logic [19:0]     w_pend_rest;
    logic [c_EW-1:0] w_entry;
    logic [c_EW-1:0] w_head;

    function automatic logic [4:0] f_lowest(input logic [19:0] m);
        f_lowest = 5'd0;
        for (int i = 19; i >= 0; i--) begin
            if (m[i]) f_lowest = 5'(i);
        end
    endfunction

    assign w_stable_next = (r_raw != r_prev)  ? 4'd1 :
                           (r_stable == 4'hF) ? 4'hF : r_stable + 4'd1;
    assign w_bit       = f_lowest(r_pend);
    // keys already holds the new state, so a cleared bit means a release
    assign w_is_rel    = !r_keys[w_bit];
    assign w_emit      = (r_state == S_EMIT) && (r_pend != 20'd0);
    assign w_pend_rest = r_pend & (r_pend - 20'd1);

    assign evt_valid   = (r_count != '0);
    assign w_full      = (r_count == c_DEPTH);
    assign w_pop       = evt_valid && evt_ready;
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_head      = r_mem[r_rd];

`ifdef KEYPAD_SCAN_RELEASE_EN
    assign w_push      = w_emit;
    assign w_entry     = {w_is_rel, w_bit};
    assign evt_key     = evt_valid ? w_head[4:0] : r_last[4:0];
    assign evt_release = evt_valid ? w_head[5]   : r_last[5];
`else
    assign w_push      = w_emit && !w_is_rel;
    assign w_entry     = w_bit;
    assign evt_key     = evt_valid ? w_head : r_last;
    assign evt_release = 1'b0;
`endif

    assign col      = r_col;
    assign keys     = r_keys;
    assign overflow = r_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_idx    <= 3'd0;
            r_cnt    <= 8'd0;
            r_col    <= 5'd0;
            r_raw    <= 20'd0;
            r_prev   <= 20'd0;
            r_stable <= 4'd0;
            r_keys   <= 20'd0;
            r_pend   <= 20'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_col <= 5'd0;
                    if (scan_en) begin
                        r_state <= S_DRIVE;
                        r_idx   <= 3'd4;
                        r_cnt   <= 8'd0;
                        r_col   <= 5'b10000;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == c_SETTLE_END) begin
                        r_state <= S_SAMPLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (!scan_en) begin
                        r_state <= S_IDLE;
                        r_col   <= 5'd0;
                        r_raw   <= 20'd0;
                    end else begin
                        case (r_idx)
                            3'd4:    r_raw[3:0]   <= row;
                            3'd3:    r_raw[7:4]   <= row;
                            3'd2:    r_raw[11:8]  <= row;
                            3'd1:    r_raw[15:12] <= row;
                            default: r_raw[19:16] <= {row[3], row[0], row[2], row[1]};
                        endcase
                        if (r_idx != 3'd0) begin
                            r_state <= S_DRIVE;
                            r_idx   <= r_idx - 3'd1;
                            r_col   <= r_col >> 1;
                        end else begin
                            r_state <= S_COMPARE;
                            r_col   <= 5'd0;
                        end
                    end
                end
                S_COMPARE: begin
                    r_prev   <= r_raw;
                    r_stable <= w_stable_next;
                    if ((w_stable_next >= c_DEB) && (r_raw != r_keys)) begin
                        r_pend  <= r_raw ^ r_keys;
                        r_keys  <= r_raw;
                        r_state <= S_EMIT;
                    end else if (scan_en) begin
                        r_state <= S_DRIVE;
                        r_idx   <= 3'd4;
                        r_cnt   <= 8'd0;
                        r_col   <= 5'b10000;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    r_pend <= w_pend_rest;
                    if (w_pend_rest == 20'd0) begin
                        if (scan_en) begin
                            r_state <= S_DRIVE;
                            r_idx   <= 3'd4;
                            r_cnt   <= 8'd0;
                            r_col   <= 5'b10000;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_col   <= 5'd0;
                end
            endcase
        end
    end

    // Storage is only visible through the head pointer while non-empty
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= w_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_last  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            else if (w_push) r_ovf <= 1'b1;
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_last <= w_head;
            end
            if (w_push_ok && !w_pop) r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
//  Module      : tb_keypad_scan
//  Description : Self-checking bench for keypad_scan with a scan-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_scan;

    localparam int c_DEB   = 3;
    localparam int c_DEPTH = 4;
`ifdef KEYPAD_SCAN_RELEASE_EN
    localparam bit c_REL = 1'b1;
`else
    localparam bit c_REL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scan_en = 1'b0;
    logic        evt_ready = 1'b0;
    logic [4:0]  col;
    logic [3:0]  row;
    logic        evt_valid;
    logic [4:0]  evt_key;
    logic        evt_release;
    logic [19:0] keys;
    logic        overflow;

    keypad_scan #(.SETTLE_CYCLES(16), .DEBOUNCE_SCANS(c_DEB), .FIFO_DEPTH(c_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .col(col), .row(row),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
        .evt_release(evt_release), .keys(keys), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [19:0] mask = '0;
    bit          rand_ready = 1'b0;
    bit          mon_en = 1'b0;

    typedef struct packed {
        logic [4:0] key;
        logic       rel;
    } evt_t;
    evt_t        exp_q[$];
    logic [19:0] m_prev, m_keys;
    int          m_stable;

    // Physical key position for column bit c, row r
    function automatic int code_of(input int c, input int r);
        if (c > 0) return (4 - c) * 4 + r;
        case (r)
            0:       return 18;
            1:       return 16;
            2:       return 17;
            default: return 19;
        endcase
    endfunction

    always_comb begin
        row = '0;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 4; r++)
                if (col[c] && mask[code_of(c, r)]) row[r] = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One full-matrix snapshot seen by the debouncer; ready_low means the
    // consumer is stalled for the whole burst, so the FIFO depth limits it.
    task automatic model_scan(input logic [19:0] snap, input bit ready_low);
        evt_t e;
        if (snap == m_prev) m_stable = (m_stable < 15) ? m_stable + 1 : 15;
        else m_stable = 1;
        m_prev = snap;
        if (m_stable >= c_DEB && snap != m_keys) begin
            for (int i = 0; i < 20; i++) begin
                if (snap[i] != m_keys[i] && (snap[i] || c_REL)) begin
                    e.key = 5'(i);
                    e.rel = !snap[i];
                    if (!ready_low || exp_q.size() < c_DEPTH) exp_q.push_back(e);
                end
            end
            m_keys = snap;
        end
    endtask

    task automatic wait_scan_start();
        logic [4:0] p;
        p = col;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (col == 5'b10000 && p != 5'b10000) return;
            p = col;
        end
        chk("scan_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_scans(input logic [19:0] m, input int n, input bit ready_low);
        repeat (n) begin
            wait_scan_start();
            chk("keys", 32'(keys), 32'(m_keys));
            mask = m;
            model_scan(m, ready_low);
        end
    endtask

    always @(negedge clk) begin
        evt_t e;
        if (mon_en && reset_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(evt_key), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("evt_key", 32'(evt_key), 32'(e.key));
                chk("evt_release", 32'(evt_release), 32'(e.rel));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int          n;
        logic [4:0]  exp_col;
        int          win[4];
        logic [19:0] m;

        m_prev = '0; m_keys = '0; m_stable = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_keys", 32'(keys), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_key", 32'(evt_key), 32'd0);
        chk("rst_rel", 32'(evt_release), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_col", 32'(col), 32'd0);

        // Column strobe order and timing with an empty matrix
        scan_en = 1'b1; evt_ready = 1'b1; mon_en = 1'b1;
        wait_scan_start();
        model_scan('0, 1'b0);
        exp_col = 5'b10000;
        for (int c = 0; c < 5; c++) begin
            n = 0;
            while (col == exp_col && n < 40) begin
                n++;
                @(posedge clk); #1;
            end
            chk("col_len", 32'(n), 32'd17);
            exp_col = exp_col >> 1;
        end
        chk("col_compare", 32'(col), 32'd0);
        chk("idle_valid", 32'(evt_valid), 32'd0);

        // Single key 5
        run_scans(20'h00020, 4, 1'b0);
        chk("keys5", 32'(keys), 32'h00020);
        run_scans('0, 4, 1'b0);

        // Keys 2 and 17 with a stalled consumer
        evt_ready = 1'b0;
        run_scans(20'h20004, 4, 1'b1);
        chk("stall_valid", 32'(evt_valid), 32'd1);
        chk("stall_head", 32'(evt_key), 32'd2);
        evt_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("drained_valid", 32'(evt_valid), 32'd0);
        chk("drained_q", 32'(exp_q.size()), 32'd0);

        // Key 9 bouncing every scan, then held
        run_scans('0, 4, 1'b0);
        for (int k = 0; k < 10; k++) run_scans((k % 2) ? 20'h00200 : 20'h0, 1, 1'b0);
        run_scans(20'h00200, 4, 1'b0);
        chk("keys9", 32'(keys), 32'h00200);

        // HALT press then release
        run_scans(20'h40000, 4, 1'b0);
        run_scans('0, 4, 1'b0);
        wait_scan_start();
        chk("halt_q", 32'(exp_q.size()), 32'd0);

        // Randomised snapshots inside a 4-key window, random consumer stalls
        rand_ready = 1'b1;
        for (int seg = 0; seg < 6; seg++) begin
            run_scans('0, 4, 1'b0);
            for (int j = 0; j < 4; j++) begin
                win[j] = $urandom_range(0, 19);
                for (int q = 0; q < j; q++)
                    if (win[q] == win[j]) begin win[j] = $urandom_range(0, 19); q = -1; end
            end
            m = '0;
            for (int s = 0; s < 12; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    m = '0;
                    for (int j = 0; j < 4; j++) if ($urandom_range(0, 1) == 1) m[win[j]] = 1'b1;
                end
                run_scans(m, 1, 1'b0);
            end
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        evt_ready = 1'b1;
        run_scans('0, 5, 1'b0);
        chk("random_q", 32'(exp_q.size()), 32'd0);
        chk("random_ovf", 32'(overflow), 32'd0);

        // Six presses into a stalled FIFO of four
        evt_ready = 1'b0;
        run_scans(20'h91089, 4, 1'b1);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_keys", 32'(keys), 32'h91089);
        chk("ovf_valid", 32'(evt_valid), 32'd1);
        chk("ovf_head", 32'(evt_key), 32'd0);

        // Asynchronous reset in the middle of a column drive
        n = 0;
        while (col != 5'b00100 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk("find_col2", 32'(col), 32'b00100);
        #2;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_col", 32'(col), 32'd0);
        chk("arst_valid", 32'(evt_valid), 32'd0);
        chk("arst_keys", 32'(keys), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        m_prev = '0; m_keys = '0; m_stable = 0;
        mask = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        evt_ready = 1'b1;
        mon_en = 1'b1;
        run_scans(20'h00001, 4, 1'b0);
        run_scans('0, 4, 1'b0);
        wait_scan_start();
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
